decode_stage: RTL

- Instruction decode stage, directly downstream of fetch.
- Each cycle it consumes the 32-bit fetch window `fetchoutput`: [31:16] is the current instruction word, [15:0] is the next word.
- Splits 16-bit and 32-bit (long) instructions into registered operand and opcode fields for execute.
- Drops fetch bubbles and the trailing half of long instructions, and raises `nop_stop` back to fetch on a halt NOP.

---
 rtl/decode_stage_pkg.sv | 31 +++
 rtl/decode_stage_if.sv | 45 ++++
 rtl/decode_stage_fields.sv | 57 +++++
 rtl/decode_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared constants for the instruction decode stage: classes, bubble words, state codes and field positions.
package aap_decode_pkg;

    localparam logic [1:0] CLS_ALU    = 2'b00;
    localparam logic [1:0] CLS_LDST   = 2'b01;
    localparam logic [1:0] CLS_BRANCH = 2'b10;
    localparam logic [1:0] CLS_MISC   = 2'b11;

    localparam logic [15:0] BUBBLE_ZERO = 16'h0000;
    localparam logic [15:0] BUBBLE_ONE  = 16'h0001;

    localparam logic [3:0] NOP_OPCODE        = 4'h0;
    localparam logic [5:0] HALT_CODE_DEFAULT = 6'd3;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam int LONG_BIT = 15;
    localparam int CLASS_HI = 14;
    localparam int CLASS_LO = 13;
    localparam int OPC_HI   = 12;
    localparam int OPC_LO   = 9;
    localparam int REG_FW   = 3;
    localparam int IMM_FW   = 6;

    function automatic logic is_bubble_word(input logic [15:0] w);
        return (w == BUBBLE_ZERO) || (w == BUBBLE_ONE);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode bus: fetch window and control in, registered decode fields out.
// With DECODE_ILLEGAL_TRAP_EN defined the bus also carries dec_illegal.
interface decode_stage_if #(
    parameter int REG_W = 6,
    parameter int OPC_W = 8,
    parameter int IMM_W = 12
);
    logic [31:0]      fetchoutput;
    logic             stall;
    logic             flush;
    logic             dec_valid;
    logic             dec_long;
    logic [1:0]       dec_class;
    logic [OPC_W-1:0] dec_opcode;
    logic [REG_W-1:0] dec_rd;
    logic [REG_W-1:0] dec_ra;
    logic [REG_W-1:0] dec_rb;
    logic [IMM_W-1:0] dec_imm;
    logic             nop_stop;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic             dec_illegal;

    modport master (
        output fetchoutput, stall, flush,
        input  dec_valid, dec_long, dec_class, dec_opcode, dec_rd, dec_ra, dec_rb,
               dec_imm, nop_stop, dec_illegal
    );
    modport slave (
        input  fetchoutput, stall, flush,
        output dec_valid, dec_long, dec_class, dec_opcode, dec_rd, dec_ra, dec_rb,
               dec_imm, nop_stop, dec_illegal
    );
`else
    modport master (
        output fetchoutput, stall, flush,
        input  dec_valid, dec_long, dec_class, dec_opcode, dec_rd, dec_ra, dec_rb,
               dec_imm, nop_stop
    );
    modport slave (
        input  fetchoutput, stall, flush,
        output dec_valid, dec_long, dec_class, dec_opcode, dec_rd, dec_ra, dec_rb,
               dec_imm, nop_stop
    );
`endif
endinterface

// File: rtl/decode_stage_fields.sv
// Purely combinational field extraction for one fetch window (w1 = current word, w2 = next word).
module decode_fields
    import aap_decode_pkg::*;
#(
    parameter int REG_W = 6,
    parameter int OPC_W = 8,
    parameter int IMM_W = 12
) (
    input  logic [15:0]      w1,
    input  logic [15:0]      w2,
    output logic             long_insn,
    output logic [1:0]       cls,
    output logic [OPC_W-1:0] opcode,
    output logic [REG_W-1:0] rd,
    output logic [REG_W-1:0] ra,
    output logic [REG_W-1:0] rb,
    output logic [IMM_W-1:0] imm,
    output logic             illegal,
    output logic             is_nop,
    output logic             is_bubble
);

    logic [REG_FW-1:0] reg_lo [3];
    logic [REG_FW-1:0] reg_hi [3];
    logic [3:0]        opc_lo;
    logic [3:0]        opc_hi;
    logic [IMM_FW-1:0] imm_lo;
    logic [IMM_FW-1:0] imm_hi;

    assign long_insn = w1[LONG_BIT];
    assign cls       = w1[CLASS_HI:CLASS_LO];
    assign opc_lo    = w1[OPC_HI:OPC_LO];
    assign imm_lo    = w1[IMM_FW-1:0];

    // Short encodings zero the upper halves; long encodings take them from w2.
    assign opc_hi = long_insn ? w2[OPC_HI:OPC_LO] : 4'h0;
    assign imm_hi = long_insn ? w2[IMM_FW-1:0]    : '0;

    // Register slots: index 0 = rb [2:0], 1 = ra [5:3], 2 = rd [8:6].
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_reg_field
            assign reg_lo[gi] = w1[gi*REG_FW +: REG_FW];
            assign reg_hi[gi] = long_insn ? w2[gi*REG_FW +: REG_FW] : '0;
        end
    endgenerate

    assign opcode = OPC_W'({opc_hi, opc_lo});
    assign rd     = REG_W'({reg_hi[2], reg_lo[2]});
    assign ra     = REG_W'({reg_hi[1], reg_lo[1]});
    assign rb     = REG_W'({reg_hi[0], reg_lo[0]});
    assign imm    = IMM_W'({imm_hi, imm_lo});

    assign illegal   = long_insn && (w2[LONG_BIT] || (w2[CLASS_HI:CLASS_LO] != cls));
    assign is_nop    = !long_insn && (cls == CLS_ALU) && (opc_lo == NOP_OPCODE);
    assign is_bubble = is_bubble_word(w1);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: RUN/SKIP/HALT sequencing and registered decode outputs, one cycle after the window.
// Optional illegal-encoding trap enabled by DECODE_ILLEGAL_TRAP_EN.
module decode_stage
    import aap_decode_pkg::*;
#(
    parameter int         REG_W     = 6,
    parameter int         OPC_W     = 8,
    parameter int         IMM_W     = 12,
    parameter logic [5:0] HALT_CODE = HALT_CODE_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    decode_stage_if.slave bus
);

    logic             f_long;
    logic [1:0]       f_cls;
    logic [OPC_W-1:0] f_opcode;
    logic [REG_W-1:0] f_rd;
    logic [REG_W-1:0] f_ra;
    logic [REG_W-1:0] f_rb;
    logic [IMM_W-1:0] f_imm;
    logic             f_illegal;
    logic             f_is_nop;
    logic             f_is_bubble;

    decode_fields #(
        .REG_W (REG_W),
        .OPC_W (OPC_W),
        .IMM_W (IMM_W)
    ) u_fields (
        .w1        (bus.fetchoutput[31:16]),
        .w2        (bus.fetchoutput[15:0]),
        .long_insn (f_long),
        .cls       (f_cls),
        .opcode    (f_opcode),
        .rd        (f_rd),
        .ra        (f_ra),
        .rb        (f_rb),
        .imm       (f_imm),
        .illegal   (f_illegal),
        .is_nop    (f_is_nop),
        .is_bubble (f_is_bubble)
    );

    logic [1:0]       state_reg,    state_next;
    logic             valid_reg,    valid_next;
    logic             long_reg,     long_next;
    logic [1:0]       class_reg,    class_next;
    logic [OPC_W-1:0] opcode_reg,   opcode_next;
    logic [REG_W-1:0] rd_reg,       rd_next;
    logic [REG_W-1:0] ra_reg,       ra_next;
    logic [REG_W-1:0] rb_reg,       rb_next;
    logic [IMM_W-1:0] imm_reg,      imm_next;
    logic             nop_stop_reg, nop_stop_next;
    logic             illegal_reg,  illegal_next;

    always_comb begin
        state_next    = state_reg;
        valid_next    = valid_reg;
        long_next     = long_reg;
        class_next    = class_reg;
        opcode_next   = opcode_reg;
        rd_next       = rd_reg;
        ra_next       = ra_reg;
        rb_next       = rb_reg;
        imm_next      = imm_reg;
        nop_stop_next = 1'b0;
        illegal_next  = 1'b0;

        if (bus.stall) begin
            illegal_next = illegal_reg;
        end else if (bus.flush) begin
            // A halted core stays halted; only reset leaves HALT.
            valid_next = 1'b0;
            if (state_reg != ST_HALT) begin
                state_next = ST_RUN;
            end
        end else begin
            case (state_reg)
                ST_SKIP: begin
                    valid_next = 1'b0;
                    state_next = ST_RUN;
                end
                ST_HALT: begin
                    valid_next = 1'b0;
                end
                default: begin
                    valid_next = 1'b0;
                    if (f_is_bubble) begin
                        valid_next = 1'b0;
                    end else if (f_long && f_illegal) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                        illegal_next  = 1'b1;
                        nop_stop_next = 1'b1;
                        state_next    = ST_HALT;
`else
                        state_next    = ST_SKIP;
`endif
                    end else if (f_is_nop) begin
                        if (f_imm == IMM_W'(HALT_CODE)) begin
                            nop_stop_next = 1'b1;
                            state_next    = ST_HALT;
                        end
                    end else begin
                        valid_next  = 1'b1;
                        long_next   = f_long;
                        class_next  = f_cls;
                        opcode_next = f_opcode;
                        rd_next     = f_rd;
                        ra_next     = f_ra;
                        rb_next     = f_rb;
                        imm_next    = f_imm;
                        if (f_long) begin
                            state_next = ST_SKIP;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_RUN;
            valid_reg    <= 1'b0;
            long_reg     <= 1'b0;
            class_reg    <= '0;
            opcode_reg   <= '0;
            rd_reg       <= '0;
            ra_reg       <= '0;
            rb_reg       <= '0;
            imm_reg      <= '0;
            nop_stop_reg <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            valid_reg    <= valid_next;
            long_reg     <= long_next;
            class_reg    <= class_next;
            opcode_reg   <= opcode_next;
            rd_reg       <= rd_next;
            ra_reg       <= ra_next;
            rb_reg       <= rb_next;
            imm_reg      <= imm_next;
            nop_stop_reg <= nop_stop_next;
            illegal_reg  <= illegal_next;
        end
    end

    assign bus.dec_valid  = valid_reg;
    assign bus.dec_long   = long_reg;
    assign bus.dec_class  = class_reg;
    assign bus.dec_opcode = opcode_reg;
    assign bus.dec_rd     = rd_reg;
    assign bus.dec_ra     = ra_reg;
    assign bus.dec_rb     = rb_reg;
    assign bus.dec_imm    = imm_reg;
    assign bus.nop_stop   = nop_stop_reg;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign bus.dec_illegal = illegal_reg;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_reg;
`endif

endmodule
